// File: rtl/i2s_tx_serializer_if.sv
// Stereo PCM frame handshake between a sample source (master) and
// i2s_tx_serializer (slave).
interface i2s_tx_serializer_if #(
   parameter int SAMPLE_W = 16
);
   logic                in_valid;
   logic                in_ready;
   logic [SAMPLE_W-1:0] in_left;
   logic [SAMPLE_W-1:0] in_right;

   modport master (
      output in_valid,
      output in_left,
      output in_right,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_left,
      input  in_right,
      output in_ready
   );
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: 2-entry frame FIFO feeding a BCK/WS/DATA serializer.
// Define I2S_TX_VOLUME_EN to add the vol_atten arithmetic-shift attenuator.
module i2s_tx_serializer #(
   parameter int SAMPLE_W = 16,
   parameter int SLOT_W   = 32,
   parameter int BCK_HALF = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
`ifdef I2S_TX_VOLUME_EN
   input  logic [3:0]         vol_atten,
`endif
   i2s_tx_serializer_if.slave in_if,
   output logic               i2s_bck,
   output logic               i2s_ws,
   output logic               i2s_data,
   output logic               underrun
);

   localparam int FRAME_BITS = 2 * SLOT_W;
   localparam int BC_W       = $clog2(FRAME_BITS);
   localparam int HC_W       = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

   typedef struct packed {
      logic [SAMPLE_W-1:0] left;
      logic [SAMPLE_W-1:0] right;
   } frame_t;

   logic [HC_W-1:0]     hc;
   logic [BC_W-1:0]     bitcnt;
   logic [BC_W-1:0]     bitcnt_next;
   logic [BC_W-1:0]     pos;
   logic [BC_W-1:0]     slot_idx;
   logic                hc_wrap;
   logic                bck_fall;
   logic                load;
   logic                right_ch;
   logic                ws_next;
   logic                data_next;
   logic [SAMPLE_W-1:0] sample;
   logic [SAMPLE_W-1:0] shifted;
   frame_t              frame_q;
   frame_t              frame_next;
   frame_t              load_frame;
   frame_t              head;

   frame_t              fifo_mem [2];
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          count;
   logic [1:0]          count_next;
   logic                fifo_empty;
   logic                push;
   logic                pop;

   // Bit-clock timing: a falling BCK edge is the only moment serial state moves.
   always_comb begin
      hc_wrap     = (hc == HC_W'(BCK_HALF - 1));
      bck_fall    = en && hc_wrap && i2s_bck;
      bitcnt_next = (bitcnt == BC_W'(FRAME_BITS - 1)) ? '0 : bitcnt + 1'b1;
      load        = bck_fall && (bitcnt_next == BC_W'(1));
   end

   always_comb begin
      fifo_empty = (count == 2'd0);
      push       = in_if.in_valid && in_if.in_ready;
      pop        = load && !fifo_empty;
      count_next = count + {1'b0, push} - {1'b0, pop};
      head       = fifo_mem[rd_ptr];
   end

   // An empty FIFO at load time yields a silent frame.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      load_frame = '0;
      if (!fifo_empty) begin
`ifdef I2S_TX_VOLUME_EN
         load_frame.left  = $signed(head.left) >>> vol_atten;
         load_frame.right = $signed(head.right) >>> vol_atten;
`else
         load_frame = head;
`endif
      end
   end

   // One-BCK I2S delay: bit position lags bitcnt by one, WS leads each MSB by one.
   always_comb begin
      frame_next = load ? load_frame : frame_q;
      pos        = (bitcnt_next == '0) ? BC_W'(FRAME_BITS - 1) : bitcnt_next - 1'b1;
      right_ch   = (pos >= BC_W'(SLOT_W));
      slot_idx   = right_ch ? pos - BC_W'(SLOT_W) : pos;
      sample     = right_ch ? frame_next.right : frame_next.left;
      shifted    = sample << slot_idx;
      data_next  = shifted[SAMPLE_W-1];
      ws_next    = (bitcnt_next >= BC_W'(SLOT_W));
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         hc       <= '0;
         bitcnt   <= '0;
         i2s_bck  <= 1'b0;
         i2s_ws   <= 1'b0;
         i2s_data <= 1'b0;
         underrun <= 1'b0;
         frame_q  <= '0;
      end else if (!en) begin
         hc       <= '0;
         bitcnt   <= '0;
         i2s_bck  <= 1'b0;
         i2s_ws   <= 1'b0;
         i2s_data <= 1'b0;
         underrun <= 1'b0;
         frame_q  <= '0;
      end else begin
         hc <= hc_wrap ? '0 : hc + 1'b1;
         if (hc_wrap) begin
            i2s_bck <= ~i2s_bck;
         end
         if (bck_fall) begin
            bitcnt   <= bitcnt_next;
            i2s_ws   <= ws_next;
            i2s_data <= data_next;
            frame_q  <= frame_next;
         end
         underrun <= load && fifo_empty;
      end
   end

   // FIFO control keeps running while the serializer is disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count          <= 2'd0;
         wr_ptr         <= 1'b0;
         rd_ptr         <= 1'b0;
         in_if.in_ready <= 1'b0;
      end else begin
         count          <= count_next;
         in_if.in_ready <= (count_next != 2'd2);
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
      end
   end

   // NOTE: the storage array is not reset; the occupancy count alone marks valid entries.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= {in_if.in_left, in_if.in_right};
      end
   end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: a frame-level reference model
// checked every clock, plus directed frames with literal expectations.
module tb_i2s_tx_serializer;

   localparam int SAMPLE_W = 16;
   localparam int SLOT_W   = 32;
   localparam int BCK_HALF = 2;
   localparam int FB       = 2 * SLOT_W;
   localparam int BCK_P    = 2 * BCK_HALF;
   localparam int FRAME_T  = FB * BCK_P;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic en    = 1'b0;
   logic i2s_bck, i2s_ws, i2s_data, underrun;
`ifdef I2S_TX_VOLUME_EN
   logic [3:0] vol_atten = 4'd0;
   logic [3:0] s_vol     = 4'd0;
`endif

   always #5 clk = ~clk;

   i2s_tx_serializer_if #(.SAMPLE_W(SAMPLE_W)) bus ();

   i2s_tx_serializer #(
      .SAMPLE_W(SAMPLE_W),
      .SLOT_W  (SLOT_W),
      .BCK_HALF(BCK_HALF)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
`ifdef I2S_TX_VOLUME_EN
      .vol_atten(vol_atten),
`endif
      .in_if    (bus),
      .i2s_bck  (i2s_bck),
      .i2s_ws   (i2s_ws),
      .i2s_data (i2s_data),
      .underrun (underrun)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Inputs as seen by each rising clock edge, plus the bench's own count of enabled clocks.
   logic        s_reset = 1'b1;
   logic        s_en    = 1'b0;
   logic        s_valid = 1'b0;
   logic [15:0] s_left  = '0;
   logic [15:0] s_right = '0;
   int          en_n    = 0;

   initial begin
      forever begin
         @(posedge clk);
         s_reset = reset;
         s_en    = en;
         s_valid = bus.in_valid;
         s_left  = bus.in_left;
         s_right = bus.in_right;
`ifdef I2S_TX_VOLUME_EN
         s_vol   = vol_atten;
`endif
         if (reset || !en) en_n = 0;
         else              en_n = en_n + 1;
      end
   end

   // Attenuation as floor division by 2^vol of the signed sample.
   function automatic logic [15:0] atten(input logic [15:0] x);
`ifdef I2S_TX_VOLUME_EN
      int v, d, q;
      v = int'($signed(x));
      d = 1 << s_vol;
      q = v / d;
      if (v < 0 && (v % d) != 0) q = q - 1;
      return q[15:0];
`else
      return x;
`endif
   endfunction

   // Reference model: FIFO as a queue, serial position derived from enabled-clock count.
   logic [31:0] mq[$];
   int          m_n     = 0;
   logic [15:0] cur_l   = '0;
   logic [15:0] cur_r   = '0;
   logic        m_ready = 1'b0;
   logic        m_und   = 1'b0;

   initial begin : model
      logic        pushed;
      logic [31:0] hd;
      logic [15:0] smp;
      int          k, b, p, j;
      logic        e_bck, e_ws, e_data;
      forever begin
         @(negedge clk);
         if (reset || s_reset) begin
            mq.delete();
            m_n     = 0;
            cur_l   = '0;
            cur_r   = '0;
            m_ready = 1'b0;
            m_und   = 1'b0;
         end else begin
            pushed = s_valid && m_ready;
            m_und  = 1'b0;
            if (s_en) begin
               m_n++;
               if (m_n % BCK_P == 0 && (m_n / BCK_P) % FB == 1) begin
                  if (mq.size() == 0) begin
                     cur_l = '0;
                     cur_r = '0;
                     m_und = 1'b1;
                  end else begin
                     hd    = mq.pop_front();
                     cur_l = atten(hd[31:16]);
                     cur_r = atten(hd[15:0]);
                  end
               end
            end else begin
               m_n   = 0;
               cur_l = '0;
               cur_r = '0;
            end
            if (pushed) mq.push_back({s_left, s_right});
            m_ready = (mq.size() < 2);
         end

         k     = m_n / BCK_P;
         e_bck = ((m_n / BCK_HALF) % 2) == 1;
         if (k == 0) begin
            e_ws   = 1'b0;
            e_data = 1'b0;
         end else begin
            b      = k % FB;
            p      = (b + FB - 1) % FB;
            e_ws   = (b >= SLOT_W);
            smp    = (p >= SLOT_W) ? cur_r : cur_l;
            j      = p % SLOT_W;
            e_data = (j < SAMPLE_W) ? smp[SAMPLE_W-1-j] : 1'b0;
         end
         check("model_bck",      i2s_bck,      e_bck);
         check("model_ws",       i2s_ws,       e_ws);
         check("model_data",     i2s_data,     e_data);
         check("model_underrun", underrun,     m_und);
         check("model_in_ready", bus.in_ready, m_ready);
      end
   end

   task automatic send(input logic [15:0] l, input logic [15:0] r, output int acc_n);
      int budget;
      budget       = 0;
      bus.in_valid = 1'b1;
      bus.in_left  = l;
      bus.in_right = r;
      while (!bus.in_ready && budget < 600) begin
         step(1);
         budget++;
      end
      step(1);
      acc_n        = en_n;
      bus.in_valid = 1'b0;
      check("send_accepted", budget < 600, 1'b1);
   endtask

   // Captures one frame starting at its left-MSB bit period.
   task automatic capture_frame(output logic [15:0] l, output logic [15:0] r,
                                output int pad_ones, output logic [FB-1:0] wsb,
                                output logic und0);
      logic [FB-1:0] db;
      int budget;
      budget = 0;
      while (en_n % FRAME_T != BCK_P && budget < 600) begin
         step(1);
         budget++;
      end
      check("frame_start_seen", budget < 600, 1'b1);
      und0 = 1'b0;
      for (int p = 0; p < FB; p++) begin
         db[p]  = i2s_data;
         wsb[p] = i2s_ws;
         if (p == 0) und0 = underrun;
         if (p < FB - 1) step(BCK_P);
      end
      pad_ones = 0;
      for (int i = 0; i < SAMPLE_W; i++) begin
         l[SAMPLE_W-1-i] = db[i];
         r[SAMPLE_W-1-i] = db[SLOT_W+i];
      end
      for (int i = SAMPLE_W; i < SLOT_W; i++) begin
         pad_ones += int'(db[i]) + int'(db[SLOT_W+i]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish before 1000000");
      $fatal(1, "watchdog expired");
   end

   initial begin : directed
      logic [15:0]   l, r;
      logic [FB-1:0] wsb;
      logic          und0;
      int            pad, acc, acc3, uc, oc, budget;

      bus.in_valid = 1'b0;
      bus.in_left  = '0;
      bus.in_right = '0;
      #1 reset = 1'b1;
      step(1);
      check("reset_bck",      i2s_bck,      1'b0);
      check("reset_ws",       i2s_ws,       1'b0);
      check("reset_data",     i2s_data,     1'b0);
      check("reset_underrun", underrun,     1'b0);
      check("reset_in_ready", bus.in_ready, 1'b0);
      reset = 1'b0;
      step(1);
      check("ready_after_reset", bus.in_ready, 1'b1);

      // Basic frame
      send(16'hA5C3, 16'h8001, acc);
      en = 1'b1;
      step(1);
      check("bck_low_clk1", i2s_bck, 1'b0);
      step(1);
      check("bck_rise_clk2", i2s_bck, 1'b1);
      capture_frame(l, r, pad, wsb, und0);
      check("t1_left",        l, 16'hA5C3);
      check("t1_right",       r, 16'h8001);
      check("t1_pad_zero",    pad, 0);
      check("t1_ws_high_cnt", $countones(wsb), 32);
      check("t1_ws_lead_r",   {wsb[31], wsb[30]}, 2'b10);
      check("t1_ws_lead_l",   wsb[63], 1'b0);
      check("t1_no_underrun", und0, 1'b0);

      // Underrun with an empty FIFO, then resume
      uc = 0;
      oc = 0;
      repeat (2 * FRAME_T) begin
         step(1);
         uc += int'(underrun);
         oc += int'(i2s_data);
      end
      check("t3_underrun_cnt", uc, 2);
      check("t3_silence_ones", oc, 0);
      send(16'h7FFF, 16'h0001, acc);
      capture_frame(l, r, pad, wsb, und0);
      check("t3_left",        l, 16'h7FFF);
      check("t3_right",       r, 16'h0001);
      check("t3_no_underrun", und0, 1'b0);

      // Back-pressure: third frame waits for the load pop
      send(16'h1357, 16'hFEDC, acc);
      send(16'h2468, 16'h0F0F, acc);
      check("t4_full_not_ready", bus.in_ready, 1'b0);
      fork
         send(16'hC0DE, 16'h7A7A, acc3);
         capture_frame(l, r, pad, wsb, und0);
      join
      check("t4_third_accept_clk", acc3 % FRAME_T, BCK_P + 1);
      check("t4_f1_left",  l, 16'h1357);
      check("t4_f1_right", r, 16'hFEDC);
      capture_frame(l, r, pad, wsb, und0);
      check("t4_f2_left",  l, 16'h2468);
      check("t4_f2_right", r, 16'h0F0F);
      capture_frame(l, r, pad, wsb, und0);
      check("t4_f3_left",  l, 16'hC0DE);
      check("t4_f3_right", r, 16'h7A7A);
      check("t4_f3_no_underrun", und0, 1'b0);

      // Reset in the middle of the right slot with a frame still queued
      send(16'h1111, 16'h2222, acc);
      send(16'h3333, 16'h4444, acc);
      budget = 0;
      while (en_n % FRAME_T != 40 * BCK_P && budget < 600) begin
         step(1);
         budget++;
      end
      check("t5_mid_right_seen", budget < 600, 1'b1);
      reset = 1'b1;
      #1;
      check("t5_bck_async",   i2s_bck,      1'b0);
      check("t5_ws_async",    i2s_ws,       1'b0);
      check("t5_data_async",  i2s_data,     1'b0);
      check("t5_ready_async", bus.in_ready, 1'b0);
      step(2);
      reset = 1'b0;
      step(1);
      check("t5_bck_clk1", i2s_bck, 1'b0);
      step(1);
      check("t5_bck_clk2", i2s_bck, 1'b1);
      capture_frame(l, r, pad, wsb, und0);
      check("t5_left_silent",  l, 16'h0000);
      check("t5_right_silent", r, 16'h0000);
      check("t5_underrun",     und0, 1'b1);

      // Disabled serializer holds outputs low but the FIFO still accepts
      en = 1'b0;
      step(1);
      check("en_off_bck",  i2s_bck,  1'b0);
      check("en_off_ws",   i2s_ws,   1'b0);
      check("en_off_data", i2s_data, 1'b0);
      send(16'hBEEF, 16'h0123, acc);
      step(3);
      check("en_off_bck_held", i2s_bck, 1'b0);
      en = 1'b1;
      capture_frame(l, r, pad, wsb, und0);
      check("en_on_left",  l, 16'hBEEF);
      check("en_on_right", r, 16'h0123);
      check("en_on_no_underrun", und0, 1'b0);

`ifdef I2S_TX_VOLUME_EN
      vol_atten = 4'd1;
      send(16'h8000, 16'h4000, acc);
      capture_frame(l, r, pad, wsb, und0);
      check("vol1_left",  l, 16'hC000);
      check("vol1_right", r, 16'h2000);
      vol_atten = 4'd15;
      send(16'h8000, 16'h4000, acc);
      capture_frame(l, r, pad, wsb, und0);
      check("vol15_left",  l, 16'hFFFF);
      check("vol15_right", r, 16'h0000);
      vol_atten = 4'd0;
      send(16'h8000, 16'h4000, acc);
      capture_frame(l, r, pad, wsb, und0);
      check("vol0_left",  l, 16'h8000);
      check("vol0_right", r, 16'h4000);
`endif

      step(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
